// File: rtl/clock_divider_ctrl_if.sv
// clock_divider_ctrl_if: valid/ready half-period config port with applied strobe
interface clock_divider_ctrl_if #(parameter int DIV_W = 16);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_half_period;
  logic             cfg_ready;
  logic             cfg_applied;
  modport master(output cfg_valid, cfg_half_period, input cfg_ready, cfg_applied);
  modport slave(input cfg_valid, cfg_half_period, output cfg_ready, cfg_applied);
endinterface

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: runtime-programmable clock divider that only stops or changes ratio at a falling toggle
// Optional burst mode (fixed count of clk_out periods per enable) when CLKDIV_BURST_EN is defined.
module clock_divider_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 3
`ifdef CLKDIV_BURST_EN
  , parameter int BURST_W   = 8
`endif
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  clock_divider_ctrl_if.slave cfg,
`ifdef CLKDIV_BURST_EN
  input  logic [BURST_W-1:0]  burst_len,
  output logic                burst_done,
`endif
  output logic                clk_out,
  output logic                tick,
  output logic                rise,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] half_q, half_d, shadow_q, shadow_d, cnt_q, cnt_d, req;
  logic             clk_q, clk_d, tick_q, tick_d, rise_q, rise_d, applied_q, applied_d;
  logic             xfer, wrap, fall, go;
`ifdef CLKDIV_BURST_EN
  logic [BURST_W-1:0] blen_q, blen_d, periods_q, periods_d;
  logic               hold_q, hold_d, done_q, done_d;
  assign burst_done = done_q;
`endif
  assign cfg.cfg_ready   = state_q == IDLE || state_q == RUN;
  assign cfg.cfg_applied = applied_q;
  assign clk_out         = clk_q;
  assign tick            = tick_q;
  assign rise            = rise_q;
  assign busy            = state_q != IDLE;
  always_comb begin
    xfer      = cfg.cfg_valid && cfg.cfg_ready;
    req       = cfg.cfg_half_period == '0 ? DIV_W'(1) : cfg.cfg_half_period;
    wrap      = state_q != IDLE && cnt_q == half_q - DIV_W'(1);
    fall      = wrap && clk_q;
    cnt_d     = (wrap || state_q == IDLE) ? '0 : cnt_q + DIV_W'(1);
    clk_d     = clk_q ^ wrap;
    tick_d    = wrap;
    rise_d    = wrap && !clk_q;
    applied_d = 1'b0;
    half_d    = half_q;
    shadow_d  = shadow_q;
    state_d   = state_q;
`ifdef CLKDIV_BURST_EN
    go        = enable && !hold_q;
    hold_d    = hold_q && enable;
    blen_d    = (state_q == IDLE && go) ? burst_len : blen_q;
    periods_d = state_q == IDLE ? '0 : periods_q + BURST_W'(fall);
    done_d    = 1'b0;
`else
    go        = enable;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          half_d    = req;
          applied_d = 1'b1;
        end
        if (go) state_d = RUN;
      end
      RUN: begin
        if (xfer) begin
          shadow_d = req;
          state_d  = PEND;
        end else if (!enable) state_d = STOP;
      end
      PEND: begin
        if (fall) begin
          half_d    = shadow_q;
          applied_d = 1'b1;
          state_d   = enable ? RUN : IDLE;
        end
      end
      default: state_d = enable ? RUN : (fall ? IDLE : STOP);
    endcase
`ifdef CLKDIV_BURST_EN
    // a completed burst overrides any return to RUN and waits for enable to cycle low
    if (fall && blen_q != '0 && periods_d == blen_q) begin
      state_d = IDLE;
      done_d  = 1'b1;
      hold_d  = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      half_q    <= DIV_W'(DIV_DEFAULT);
      shadow_q  <= '0;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      rise_q    <= 1'b0;
      applied_q <= 1'b0;
`ifdef CLKDIV_BURST_EN
      blen_q    <= '0;
      periods_q <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      rise_q    <= rise_d;
      applied_q <= applied_d;
`ifdef CLKDIV_BURST_EN
      blen_q    <= blen_d;
      periods_q <= periods_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
`endif
    end
  end
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: directed scenarios plus randomized run checked against a countdown-style reference model
module tb_clock_divider_ctrl;
  logic clk_in = 1'b0, reset = 1'b0, enable = 1'b0;
  logic clk_out, tick, rise, busy;
  int checks = 0, errors = 0;
  clock_divider_ctrl_if #(.DIV_W(16)) cfg_if();
`ifdef CLKDIV_BURST_EN
  logic [7:0] burst_len = 8'd0;
  logic       burst_done;
`endif
  clock_divider_ctrl #(.DIV_W(16), .DIV_DEFAULT(3)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .cfg(cfg_if),
`ifdef CLKDIV_BURST_EN
    .burst_len(burst_len), .burst_done(burst_done),
`endif
    .clk_out(clk_out), .tick(tick), .rise(rise), .busy(busy));
  always #5 clk_in = ~clk_in;

  // reference: level plus cycles remaining in that level, with pending/stopping flags
  bit m_run, m_lvl, m_pend, m_stop, m_tick, m_rise, m_app;
  int m_left, m_half, m_shadow;
  function automatic bit m_ready();
    return !m_run || (!m_pend && !m_stop);
  endfunction
  task automatic model_reset();
    {m_run, m_lvl, m_pend, m_stop, m_tick, m_rise, m_app} = '0;
    m_left = 0; m_half = 3; m_shadow = 0;
  endtask
  task automatic model_update(input bit en, input bit v, input int d);
    bit xfer, toggled, falling;
    int val;
    xfer = v && m_ready();
    val = (d == 0) ? 1 : d;
    m_app = 0; m_tick = 0; m_rise = 0;
    if (!m_run) begin
      if (xfer) begin m_half = val; m_app = 1; end
      if (en) begin m_run = 1; m_left = m_half; m_pend = 0; m_stop = 0; end
    end else begin
      m_left--;
      toggled = (m_left == 0);
      falling = toggled && m_lvl;
      if (toggled) begin m_tick = 1; m_rise = !m_lvl; m_lvl = !m_lvl; end
      if (m_pend) begin
        if (falling) begin m_half = m_shadow; m_app = 1; m_pend = 0; if (!en) m_run = 0; end
      end else if (m_stop) begin
        if (en) m_stop = 0; else if (falling) m_run = 0;
      end else if (xfer) begin m_shadow = val; m_pend = 1; end
      else if (!en) m_stop = 1;
      if (toggled) m_left = m_half;
    end
  endtask

  task automatic step(input bit en, input bit v, input int d);
    enable = en; cfg_if.cfg_valid = v; cfg_if.cfg_half_period = 16'(d);
    @(posedge clk_in);
    model_update(en, v, d);
    #1;
  endtask
  // mode 0: wait for a rise; mode 1: wait for a fall; n is the number of cycles taken
  task automatic run_until(input bit en, input bit mode, output int n);
    n = 0;
    do begin step(en, 1'b0, 0); n++; end
    while (!(mode ? (tick && !clk_out) : rise) && n < 64);
  endtask
  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; cfg_if.cfg_valid = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; cfg_if.cfg_valid = 1'b0; cfg_if.cfg_half_period = '0;
    #1;
    checks++;
    if ({clk_out, tick, rise, busy, cfg_if.cfg_applied, cfg_if.cfg_ready} !== 6'b000001) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000001", {clk_out, tick, rise, busy, cfg_if.cfg_applied, cfg_if.cfg_ready});
    end
    enable = 1'b1;
    @(posedge clk_in); #1;
    checks++;
    if ({clk_out, busy} !== 2'b00) begin errors++; $display("FAIL reset_held: got %b expected 00", {clk_out, busy}); end
    do_reset();
  endtask

  task automatic test_default_run();
    int nt = 0, nr = 0, n;
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) begin step(1, 0, 0); nt += tick; nr += rise; end
    checks++; if (nt != 10) begin errors++; $display("FAIL t1_ticks: got %0d expected 10", nt); end
    checks++; if (nr != 5) begin errors++; $display("FAIL t1_rises: got %0d expected 5", nr); end
    run_until(1, 0, n);
    checks++; if (n != 3) begin errors++; $display("FAIL t1_low_phase: got %0d expected 3", n); end
    run_until(1, 1, n);
    checks++; if (n != 3) begin errors++; $display("FAIL t1_high_phase: got %0d expected 3", n); end
  endtask

  task automatic test_cfg_idle();
    int n;
    do_reset();
    step(0, 1, 5);
    checks++; if (cfg_if.cfg_applied !== 1'b1) begin errors++; $display("FAIL t2_applied: got %b expected 1", cfg_if.cfg_applied); end
    step(0, 0, 0);
    checks++; if (cfg_if.cfg_applied !== 1'b0) begin errors++; $display("FAIL t2_applied_pulse: got %b expected 0", cfg_if.cfg_applied); end
    step(1, 0, 0);
    run_until(1, 0, n);
    checks++; if (n != 5) begin errors++; $display("FAIL t2_first_rise: got %0d expected 5", n); end
    run_until(1, 0, n);
    checks++; if (n != 10) begin errors++; $display("FAIL t2_period: got %0d expected 10", n); end
  endtask

  task automatic test_cfg_pend();
    int n, hi, bad = 0;
    do_reset();
    step(1, 0, 0);
    run_until(1, 0, n);
    step(1, 1, 1);
    hi = 1;
    checks++; if ({cfg_if.cfg_ready, busy} !== 2'b01) begin errors++; $display("FAIL t3_pend_ready: got %b expected 01", {cfg_if.cfg_ready, busy}); end
    while (clk_out && hi < 64) begin bad += cfg_if.cfg_ready; step(1, 0, 0); hi++; end
    checks++; if (hi != 3) begin errors++; $display("FAIL t3_high_len: got %0d expected 3", hi); end
    checks++; if (bad != 0) begin errors++; $display("FAIL t3_ready_high: got %0d cycles expected 0", bad); end
    checks++; if ({cfg_if.cfg_applied, cfg_if.cfg_ready} !== 2'b11) begin errors++; $display("FAIL t3_apply_at_fall: got %b expected 11", {cfg_if.cfg_applied, cfg_if.cfg_ready}); end
    run_until(1, 0, n);
    checks++; if (n != 1) begin errors++; $display("FAIL t3_new_low: got %0d expected 1", n); end
    run_until(1, 0, n);
    checks++; if (n != 2) begin errors++; $display("FAIL t3_new_period: got %0d expected 2", n); end
  endtask

  task automatic test_stop();
    int n, nt = 0, nh = 0;
    do_reset();
    step(0, 1, 4);
    step(1, 0, 0);
    run_until(1, 0, n);
    checks++; if (n != 4) begin errors++; $display("FAIL t4_first_rise: got %0d expected 4", n); end
    step(1, 0, 0);
    run_until(0, 1, n);
    checks++; if (n + 1 != 4) begin errors++; $display("FAIL t4_high_len: got %0d expected 4", n + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_idle: busy got %b expected 0", busy); end
    for (int i = 0; i < 10; i++) begin step(0, 0, 0); nt += tick; nh += clk_out; end
    checks++; if (nt + nh != 0) begin errors++; $display("FAIL t4_stopped: got %0d ticks %0d high expected 0", nt, nh); end
  endtask

  task automatic test_cfg_zero();
    int nt = 0, nr = 0, nc = 0;
    logic prev;
    do_reset();
    step(0, 1, 0);
    checks++; if (cfg_if.cfg_applied !== 1'b1) begin errors++; $display("FAIL t5_applied: got %b expected 1", cfg_if.cfg_applied); end
    step(1, 0, 0);
    prev = clk_out;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      nt += tick; nr += rise; nc += (clk_out != prev); prev = clk_out;
    end
    checks++; if (nt != 8 || nc != 8) begin errors++; $display("FAIL t5_div2: got %0d ticks %0d toggles expected 8", nt, nc); end
    checks++; if (nr != 4) begin errors++; $display("FAIL t5_rises: got %0d expected 4", nr); end
  endtask

  task automatic test_reset_pend();
    int n;
    do_reset();
    step(1, 0, 0);
    run_until(1, 0, n);
    step(1, 1, 5);
    checks++; if ({cfg_if.cfg_ready, busy} !== 2'b01) begin errors++; $display("FAIL t6_pend: got %b expected 01", {cfg_if.cfg_ready, busy}); end
    step(1, 0, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, rise, busy, cfg_if.cfg_applied, cfg_if.cfg_ready} !== 6'b000001) begin
      errors++; $display("FAIL t6_async_reset: got %b expected 000001", {clk_out, tick, rise, busy, cfg_if.cfg_applied, cfg_if.cfg_ready});
    end
    #2;
    model_reset();
    reset = 1'b1;
    step(1, 0, 0);
    run_until(1, 0, n);
    checks++; if (n != 3) begin errors++; $display("FAIL t6_default_half: got %0d expected 3", n); end
    run_until(1, 1, n);
    checks++; if (n != 3) begin errors++; $display("FAIL t6_discarded_cfg: got %0d expected 3", n); end
  endtask

  task automatic test_random();
    bit en = 1'b1, v;
    int d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) en = !en;
      v = ($urandom_range(0, 4) == 0);
      d = $urandom_range(0, 4);
      step(en, v, d);
      checks++;
      if ({clk_out, tick, rise, busy, cfg_if.cfg_ready, cfg_if.cfg_applied} !== {m_lvl, m_tick, m_rise, m_run, m_ready(), m_app}) begin
        errors++;
        $display("FAIL random_cycle%0d: got clk/tick/rise/busy/ready/applied=%b expected %b", i,
          {clk_out, tick, rise, busy, cfg_if.cfg_ready, cfg_if.cfg_applied}, {m_lvl, m_tick, m_rise, m_run, m_ready(), m_app});
      end
    end
  endtask

`ifdef CLKDIV_BURST_EN
  task automatic test_burst();
    int nr = 0, nd = 0, late = 0;
    do_reset();
    burst_len = 8'd2;
    step(0, 1, 2);
    step(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0);
      if (nd > 0) late += tick;
      nr += rise; nd += burst_done;
    end
    checks++; if (nr != 2) begin errors++; $display("FAIL t7_rises: got %0d expected 2", nr); end
    checks++; if (nd != 1) begin errors++; $display("FAIL t7_done: got %0d expected 1", nd); end
    checks++; if (late != 0 || busy !== 1'b0) begin errors++; $display("FAIL t7_stopped: got %0d ticks busy=%b expected 0", late, busy); end
    burst_len = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_default_run();
    test_cfg_idle();
    test_cfg_pend();
    test_stop();
    test_cfg_zero();
    test_reset_pend();
`ifdef CLKDIV_BURST_EN
    test_burst();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
